// File: rtl/seg_scan_n.sv
// Multiplexed seven-segment scanner for DIGITS digits.
// A free-running prescaler sets the slot timing. Inputs are captured into
// shadow registers once per frame, so every digit of a frame shows data from
// the same moment. The registered logical outputs then pass through optional
// polarity inversion on the way to the pins.

// Per-digit hex decode and dark decision.
module seg_scan_n_digit (
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       lzEn,
    input  logic       lzHit,   // this digit and every digit above it hold zero
    output logic       dark,
    output logic [6:0] segs     // {g,f,e,d,c,b,a}
);
    assign dark = blank || (lzEn && lzHit);

    // hex to segment pattern, full 0-F
    always_comb begin
        segs = 7'h00;
        case (nib)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            4'hF: segs = 7'h71;
            default: segs = 7'h00;
        endcase
    end
endmodule

module seg_scan_n #(
    parameter int DIGITS         = 4,
    parameter int SCAN_LOG2      = 18,
    parameter int BRIGHT_W       = 3,
    parameter bit POS_ACTIVE_LOW = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   dataBus,
    input  logic [DIGITS-1:0]     dpMask,
    input  logic [DIGITS-1:0]     blankMask,
    input  logic                  lzBlank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     pos,
    output logic [7:0]            seg,
    output logic                  frameTick
);
    localparam int              PW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIGITS - 1);

    logic [SCAN_LOG2-1:0]       divCnt;
    logic [PW-1:0]              posC;
    logic                       primed;
    logic                       slotEnd;
    logic                       load;

    logic [DIGITS-1:0][3:0]     shData;
    logic [DIGITS-1:0]          shDp;
    logic [DIGITS-1:0]          shBlank;
    logic                       shLz;
    logic [BRIGHT_W-1:0]        shBright;

    logic [DIGITS-1:0][3:0]     nib;
    logic [DIGITS-1:0]          effDp;
    logic [DIGITS-1:0]          effBlank;
    logic                       effLz;
    logic [BRIGHT_W-1:0]        effBright;

    logic [DIGITS:1]            hiZero;
    logic [DIGITS-1:0]          lzHit;
    logic [DIGITS-1:0]          dark;
    logic [DIGITS-1:0][6:0]     digSeg;

    logic [BRIGHT_W-1:0]        phase;
    logic                       lit;
    logic [DIGITS-1:0]          posL;
    logic [7:0]                 segL;

    assign slotEnd = &divCnt;
    assign load    = !primed || (slotEnd && (posC == LAST));

    // prescaler and digit slot counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt <= '0;
            posC   <= '0;
        end else begin
            divCnt <= divCnt + SCAN_LOG2'(1);
            if (slotEnd)
                posC <= (posC == LAST) ? '0 : posC + PW'(1);
        end
    end

    // frame-synchronous shadow capture; frameTick marks each capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed    <= 1'b0;
            shData    <= '0;
            shDp      <= '0;
            shBlank   <= '0;
            shLz      <= 1'b0;
            shBright  <= '0;
            frameTick <= 1'b0;
        end else begin
            primed    <= 1'b1;
            frameTick <= load;
            if (load) begin
                shData   <= dataBus;
                shDp     <= dpMask;
                shBlank  <= blankMask;
                shLz     <= lzBlank;
                shBright <= bright;
            end
        end
    end

    // The first edge after reset both captures the inputs and renders cycle 0
    // of digit 0, so that edge looks through to the live inputs; the display
    // then shows the released value from the very first cycle.
    always_comb begin
        if (primed) begin
            nib       = shData;
            effDp     = shDp;
            effBlank  = shBlank;
            effLz     = shLz;
            effBright = shBright;
        end else begin
            nib       = dataBus;
            effDp     = dpMask;
            effBlank  = blankMask;
            effLz     = lzBlank;
            effBright = bright;
        end
    end

    // leading-zero chain from the most significant digit down; digit 0 never joins
    assign hiZero[DIGITS] = (nib[DIGITS-1] == 4'h0);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            if (g == 0) begin : g_lsd
                assign lzHit[g] = 1'b0;
            end else begin : g_hi
                if (g < DIGITS - 1) begin : g_mid
                    assign hiZero[g + 1] = hiZero[g + 2] && (nib[g] == 4'h0);
                end
                assign lzHit[g] = hiZero[g + 1];
            end

            seg_scan_n_digit u_dig (
                .nib   (nib[g]),
                .blank (effBlank[g]),
                .lzEn  (effLz),
                .lzHit (lzHit[g]),
                .dark  (dark[g]),
                .segs  (digSeg[g])
            );
        end
    endgenerate

    // PWM phase is the top bits of the slot counter, so each slot is lit from its start
    assign phase = divCnt[SCAN_LOG2-1 -: BRIGHT_W];
    assign lit   = !dark[posC] && (phase <= effBright);

    // logical output register: one-hot digit and its pattern, or fully dark
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            posL <= '0;
            segL <= '0;
        end else if (lit) begin
            posL <= DIGITS'(1) << posC;
            segL <= {effDp[posC], digSeg[posC]};
        end else begin
            posL <= '0;
            segL <= '0;
        end
    end

    // board polarity; the reset level follows automatically
    assign pos = posL ^ {DIGITS{POS_ACTIVE_LOW}};
    assign seg = segL ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg_scan_n.sv
// Bench for seg_scan_n at DIGITS=4, SCAN_LOG2=4, BRIGHT_W=2.
// dut0 uses active-high outputs and dut1 active-low outputs, and both share
// the same stimulus. A frame-level reference model predicts every output cycle.
module tb_seg_scan_n;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] dataBus = '0;
    logic [3:0]  dpMask = '0, blankMask = '0;
    logic        lzBlank = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [3:0]  pos0, pos1;
    logic [7:0]  seg0, seg1;
    logic        tick0, tick1;

    int checks = 0;
    int failures = 0;

    seg_scan_n #(.DIGITS(4), .SCAN_LOG2(4), .BRIGHT_W(2),
                 .POS_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .dataBus(dataBus), .dpMask(dpMask),
        .blankMask(blankMask), .lzBlank(lzBlank), .bright(bright),
        .pos(pos0), .seg(seg0), .frameTick(tick0));

    seg_scan_n #(.DIGITS(4), .SCAN_LOG2(4), .BRIGHT_W(2),
                 .POS_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .dataBus(dataBus), .dpMask(dpMask),
        .blankMask(blankMask), .lzBlank(lzBlank), .bright(bright),
        .pos(pos1), .seg(seg1), .frameTick(tick1));

    always #5 clk = ~clk;

    logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: cycle c of the scan; slot = c/16 mod 4, PWM phase = quarter of the slot
    function automatic logic [11:0] ref_out(int c, logic [15:0] d, logic [3:0] dp,
                                            logic [3:0] bl, logic lz, logic [1:0] br);
        int slot, phase;
        logic [15:0] hi;
        slot  = (c / 16) % 4;
        phase = (c % 16) / 4;
        hi    = d >> (4 * slot);
        if (bl[slot] || (lz && slot != 0 && hi == 16'h0) || phase > int'(br))
            return 12'h000;
        return {4'(1 << slot), dp[slot], DEC[hi[3:0]]};
    endfunction

    // Model state: cycles since release and the data frozen for the current frame
    int          n;
    logic [15:0] fD;
    logic [3:0]  fDp, fBl;
    logic        fLz;
    logic [1:0]  fBr;
    logic [3:0]  expPos;
    logic [7:0]  expSeg;
    logic        expTick;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n <= 0; expPos <= '0; expSeg <= '0; expTick <= 1'b0;
            fD <= '0; fDp <= '0; fBl <= '0; fLz <= 1'b0; fBr <= '0;
        end else begin
            n <= n + 1;
            if (n == 0)
                {expPos, expSeg} <= ref_out(0, dataBus, dpMask, blankMask, lzBlank, bright);
            else
                {expPos, expSeg} <= ref_out(n, fD, fDp, fBl, fLz, fBr);
            expTick <= (n == 0) || ((n + 1) % 64 == 0);
            if (n == 0 || (n + 1) % 64 == 0) begin
                fD <= dataBus; fDp <= dpMask; fBl <= blankMask; fLz <= lzBlank; fBr <= bright;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pos0, seg0, tick0} !== 13'h0) begin
            failures++; $display("FAIL reset_lvl0 got pos=%b seg=%h tick=%b want 0/00/0", pos0, seg0, tick0);
        end
        checks++;
        if ({pos1, seg1, tick1} !== {4'hF, 8'hFF, 1'b0}) begin
            failures++; $display("FAIL reset_lvl1 got pos=%b seg=%h tick=%b want 1111/FF/0", pos1, seg1, tick1);
        end
    endtask

    task automatic test_scan();
        logic [7:0] sc [4] = '{8'h71, 8'h77, 8'h5B, 8'h06};
        int slot;
        dataBus = 16'h12AF; dpMask = '0; blankMask = '0; lzBlank = 1'b0; bright = 2'd3;
        do_reset();
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            checks++;
            if ({pos0, seg0, tick0} !== {expPos, expSeg, expTick}) begin
                failures++; $display("FAIL scan_model k=%0d got %b/%h/%b want %b/%h/%b", k, pos0, seg0, tick0, expPos, expSeg, expTick);
            end
            slot = ((k - 1) / 16) % 4;
            if ((k - 1) % 16 == 8) begin
                checks++;
                if ({pos0, seg0} !== {4'(1 << slot), sc[slot]}) begin
                    failures++; $display("FAIL scan_slot k=%0d got %b/%h want %b/%h", k, pos0, seg0, 4'(1 << slot), sc[slot]);
                end
            end
            checks++;
            if (tick0 !== (k == 1 || k == 64 || k == 128)) begin
                failures++; $display("FAIL scan_tick k=%0d got %b", k, tick0);
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] pat [3] = '{16'h0005, 16'h0000, 16'h0500};
        logic [11:0] want [3][4] = '{'{12'h16D, 12'h000, 12'h000, 12'h000},
                                    '{12'h13F, 12'h000, 12'h000, 12'h000},
                                    '{12'h13F, 12'h23F, 12'h46D, 12'h000}};
        int slot;
        lzBlank = 1'b1; bright = 2'd3; dpMask = '0; blankMask = '0;
        for (int p = 0; p < 3; p++) begin
            dataBus = pat[p];
            do_reset();
            for (int k = 1; k <= 64; k++) begin
                @(negedge clk);
                checks++;
                if ({pos0, seg0, tick0} !== {expPos, expSeg, expTick}) begin
                    failures++; $display("FAIL lz_model p=%0d k=%0d got %b/%h want %b/%h", p, k, pos0, seg0, expPos, expSeg);
                end
                slot = (k - 1) / 16;
                if ((k - 1) % 16 == 2) begin
                    checks++;
                    if ({pos0, seg0} !== want[p][slot]) begin
                        failures++; $display("FAIL lz_slot p=%0d slot=%0d got %h want %h", p, slot, {pos0, seg0}, want[p][slot]);
                    end
                end
            end
        end
        lzBlank = 1'b0;
    endtask

    task automatic test_bright();
        logic wantLit;
        dataBus = 16'h8888; dpMask = '0; blankMask = '0; lzBlank = 1'b0;
        for (int b = 1; b >= 0; b--) begin
            bright = 2'(b);
            do_reset();
            for (int k = 1; k <= 64; k++) begin
                @(negedge clk);
                checks++;
                if ({pos0, seg0, tick0} !== {expPos, expSeg, expTick}) begin
                    failures++; $display("FAIL bright_model b=%0d k=%0d got %b/%h want %b/%h", b, k, pos0, seg0, expPos, expSeg);
                end
                wantLit = ((k - 1) % 16) < (b == 1 ? 8 : 4);
                checks++;
                if ((pos0 != 4'h0) !== wantLit) begin
                    failures++; $display("FAIL bright_window b=%0d k=%0d got pos=%b want lit=%b", b, k, pos0, wantLit);
                end
            end
        end
        bright = 2'd3;
    endtask

    task automatic test_midframe();
        dataBus = 16'h1111; dpMask = '0; blankMask = '0; lzBlank = 1'b0; bright = 2'd3;
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            checks++;
            if ({pos0, seg0, tick0} !== {expPos, expSeg, expTick}) begin
                failures++; $display("FAIL mid_model k=%0d got %b/%h/%b want %b/%h/%b", k, pos0, seg0, tick0, expPos, expSeg, expTick);
            end
            if (k == 25 || k == 41 || k == 57) begin
                checks++;
                if (seg0 !== 8'h06) begin
                    failures++; $display("FAIL mid_hold k=%0d got seg=%h want 06", k, seg0);
                end
            end
            if (k == 73) begin
                checks++;
                if ({pos0, seg0} !== {4'b0001, 8'h5B}) begin
                    failures++; $display("FAIL mid_new got %b/%h want 0001/5B", pos0, seg0);
                end
            end
            if (k == 24) dataBus = 16'h2222;
        end
    endtask

    task automatic test_polarity();
        logic [11:0] want [4] = '{12'hFFF, 12'hD80, 12'hB00, 12'h780};
        dataBus = 16'h8888; dpMask = 4'b0100; blankMask = 4'b0001; lzBlank = 1'b0; bright = 2'd3;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if ({pos1, seg1} !== ~{expPos, expSeg}) begin
                failures++; $display("FAIL pol_model k=%0d got %b/%h want %b/%h", k, pos1, seg1, ~expPos, ~expSeg);
            end
            if ((k - 1) % 16 == 5) begin
                checks++;
                if ({pos1, seg1} !== want[(k - 1) / 16]) begin
                    failures++; $display("FAIL pol_slot k=%0d got %h want %h", k, {pos1, seg1}, want[(k - 1) / 16]);
                end
            end
        end
        dpMask = '0; blankMask = '0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int ticks;
        dataBus = 16'h1234; bright = 2'd3;
        do_reset();
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({pos0, seg0, tick0} !== 13'h0) begin
            failures++; $display("FAIL rstmid_async0 got %b/%h/%b want 0/00/0", pos0, seg0, tick0);
        end
        checks++;
        if ({pos1, seg1} !== 12'hFFF) begin
            failures++; $display("FAIL rstmid_async1 got %b/%h want 1111/FF", pos1, seg1);
        end
        v = 16'($urandom);
        dataBus = v;
        @(negedge clk);
        rst = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k < 64 && tick0) ticks++;
            if (k == 1) begin
                checks++;
                if ({pos0, seg0, tick0} !== {4'b0001, 1'b0, DEC[v[3:0]], 1'b1}) begin
                    failures++; $display("FAIL rstmid_first got %b/%h/%b want 0001/%h/1", pos0, seg0, tick0, {1'b0, DEC[v[3:0]]});
                end
            end
            checks++;
            if ({pos0, seg0, tick0} !== {expPos, expSeg, expTick}) begin
                failures++; $display("FAIL rstmid_model k=%0d got %b/%h want %b/%h", k, pos0, seg0, expPos, expSeg);
            end
        end
        checks++;
        if (ticks !== 1) begin
            failures++; $display("FAIL rstmid_ticks got %0d want 1", ticks);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            dataBus = 16'($urandom);
            for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 1) dataBus[4*i +: 4] = 4'h0;
            dpMask = 4'($urandom); blankMask = 4'($urandom) & 4'($urandom);
            lzBlank = 1'($urandom); bright = 2'($urandom);
            do_reset();
            for (int k = 1; k <= 300; k++) begin
                @(negedge clk);
                checks++;
                if ({pos0, seg0, tick0, pos1, seg1} !== {expPos, expSeg, expTick, ~expPos, ~expSeg}) begin
                    failures++; $display("FAIL rand_model it=%0d k=%0d got %b/%h/%b %b/%h want %b/%h/%b", it, k, pos0, seg0, tick0, pos1, seg1, expPos, expSeg, expTick);
                end
                if ($urandom_range(19, 0) == 0) begin
                    dataBus = 16'($urandom);
                    if ($urandom_range(1, 0) == 1) dataBus[15:8] = 8'h00;
                    dpMask = 4'($urandom); blankMask = 4'($urandom) & 4'($urandom);
                    lzBlank = 1'($urandom); bright = 2'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_bright();
        test_midframe();
        test_polarity();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_n.md
Name: seg_scan_n

Overview:
- Parametrised multiplexed seven-segment scanner. Drives DIGITS common-anode or common-cathode digits from one hex bus, using the system clock and an internal prescaler.
- Beyond the fixed 4-digit 190 Hz scanner, it adds:
  - full 0–F decode
  - per-digit decimal point and blank mask
  - leading-zero blanking
  - PWM brightness
  - frame-synchronous input latching, so a digit cannot change part-way through a frame
  - selectable output polarity
- Sits between display/data logic and board pins.

Parameters:
- DIGITS, 4, number of digits; legal 1..8
- SCAN_LOG2, 18, digit slot length = 2^SCAN_LOG2 clk cycles (50 MHz → ~190.7 Hz per slot); must be ≥ BRIGHT_W
- BRIGHT_W, 3, brightness control width
- POS_ACTIVE_LOW, 0, 1 inverts every pos bit at the output
- SEG_ACTIVE_LOW, 0, 1 inverts every seg bit at the output

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- dataBus  in  4*DIGITS  hex nibbles; digit i = dataBus[4i+3:4i], digit 0 rightmost
- dpMask  in  DIGITS  1 = light the decimal point of digit i
- blankMask  in  DIGITS  1 = force digit i dark
- lzBlank  in  1  1 = enable leading-zero blanking
- bright  in  BRIGHT_W  brightness; all-ones = full on
- pos  out  DIGITS  one-hot digit enable, registered, logical (before polarity)
- seg  out  8  {dp,g,f,e,d,c,b,a}, registered, logical (before polarity)
- frameTick  out  1  one-cycle pulse on each shadow load

Behaviour:
- Reset (rst=0, asynchronous):
  - divCnt=0, posC=0, primed=0, all shadow registers=0, frameTick=0
  - pos and seg at the inactive level (logical all zeros, inverted per polarity parameter)
- Prescaler: divCnt is SCAN_LOG2 bits, increments every clk and wraps naturally.
  - When divCnt is all-ones, posC advances: 0..DIGITS-1, then back to 0.
- Shadow load (dataBus, dpMask, blankMask, lzBlank, bright) happens in these cycles:
  - the first clk edge after reset release (primed=0, which then sets primed=1)
  - every cycle with divCnt all-ones and posC=DIGITS-1, i.e. the boundary into digit 0
  - frameTick=1 in the cycle after each load (registered).
- Inputs are used only through the shadow registers. Input changes mid-frame have no visible effect until the next load.
- Dark conditions for digit i (using shadow values):
  - shBlank[i]=1, or
  - lzBlank=1 and i≠0 and nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked by lzBlank, so value 0 shows "0".
- PWM on-window: phase = divCnt[SCAN_LOG2-1 -: BRIGHT_W]; lit when phase ≤ shBright.
  - Duty = (bright+1)/2^BRIGHT_W; minimum is 1/2^BRIGHT_W, never fully off.
- Output register, 1-cycle latency from divCnt/posC:
  - Lit slot: pos = one-hot(posC); seg = {shDp[posC], decode(nibble)}.
  - Dark digit or outside the on-window: pos=0, seg=0 (logical).
- Decode {g..a}, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Polarity: applied after the logical register; XOR each bit with its polarity parameter. Reset level also follows polarity.
- Never more than one pos bit active. No overlap between digit slots.
- Reset asserted mid-frame: outputs go inactive immediately. After release, scanning restarts at digit 0 with a fresh shadow load.

Test Plan:
All runs use DIGITS=4, SCAN_LOG2=4, BRIGHT_W=2 unless stated.
1. bright=3, dataBus=16'h12AF, masks 0, lzBlank=0 → four consecutive 16-cycle slots:
   - pos=0001 seg=71
   - pos=0010 seg=77
   - pos=0100 seg=5B
   - pos=1000 seg=06
   - frameTick period is 64 cycles.
2. lzBlank=1:
   - dataBus=16'h0005 → slots 1..3 give pos=0000 seg=00; slot 0 gives seg=6D.
   - dataBus=16'h0000 → slot 0 gives seg=3F.
   - dataBus=16'h0500 → slot 3 dark, slots 0,1 show 3F.
3. bright=1 → each slot lit for cycles 0..7 of the slot (phase 0,1) and dark for cycles 8..15; bright=0 → lit for cycles 0..3 only.
4. dataBus changed 16'h1111→16'h2222 in the middle of slot 1 → slots 1..3 still show 06; 5B appears only after the next frameTick.
5. dpMask=0100, blankMask=0001, POS_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1, dataBus=16'h8888:
   - slot 2: pos=1011, seg=00 (logical FF, inverted)
   - slot 0: pos=1111, seg=FF
6. rst pulled low mid-slot 2 → pos and seg inactive without waiting for a clk edge. On release, the first slot is digit 0 showing the value sampled at release, and frameTick pulses once.
